// File: rtl/rook_move_gen.sv
// rtl/rook_move_gen.sv - sequential rook/queen sliding move generator
//
// Purpose:
//   Walks the rays of the rook (or queen) on from_sq, one probe per cycle.
//   Every pseudo-legal target is offered on a valid/ready move stream.
//   A one-cycle done pulse follows the last accepted move.
//
// Optional build macro: ROOKGEN_DIAG_EN
//   When defined, a QUEEN also scans NE, NW, SE and SW after W.
//   When undefined, a QUEEN is treated exactly like a ROOK.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset; aborts a run without done
//   board        64-square board; held stable by the caller from start to done
//   from_sq      source square {row[2:0], col[2:0]}; sampled on an accepted start
//   start        one-cycle request; accepted only in IDLE
//   busy         high from the cycle after start through the done cycle
//   move_valid   move_to / move_capture hold a move offered to the consumer
//   move_ready   consumer accept; the handshake is move_valid && move_ready
//   move_to      target square of the offered move
//   move_capture target square holds an enemy piece
//   done         one-cycle completion pulse
//   move_count   moves accepted in the last run; held until the next start

package rook_move_gen_pkg;
  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_t;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } color_t;

  typedef struct packed {
    color_t color;
    piece_t piece;
  } fullpiece_t;
endpackage

module rook_move_gen
  import rook_move_gen_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  fullpiece_t [63:0]     board,
  input  logic [5:0]            from_sq,
  input  logic                  start,
  output logic                  busy,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic [5:0]            move_to,
  output logic                  move_capture,
  output logic                  done,
  output logic [CNT_W-1:0]      move_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Direction codes, scanned in numeric order:
  //   0 N, 1 S, 2 E, 3 W, 4 NE, 5 NW, 6 SE, 7 SW
  localparam logic [2:0] DIR_W  = 3'd3;
  localparam logic [2:0] DIR_SW = 3'd7;

  state_t           state, state_n;
  logic [5:0]       src, src_n;
  logic [5:0]       cur, cur_n;
  logic [2:0]       dir, dir_n;
  logic [2:0]       last_dir, last_dir_n;
  color_t           mover, mover_n;
  logic             slider, slider_n;
  logic             ray_end, ray_end_n;
  logic [5:0]       move_to_n;
  logic             move_capture_n;
  logic             move_valid_n;
  logic [CNT_W-1:0] move_count_n;

  // Candidate square one step from cur along dir.
  logic [3:0]       d_row, d_col;
  logic [3:0]       cand_row, cand_col;
  logic             cand_off;
  logic [5:0]       cand;
  fullpiece_t       cand_pc;
  fullpiece_t       src_pc;
  logic             cand_own;

  // Deltas are 4-bit two's complement: 4'h1 = +1, 4'hF = -1.
  always_comb begin
    d_row = 4'h0;
    d_col = 4'h0;
    unique case (dir)
      3'd0: begin d_row = 4'h1; d_col = 4'h0; end
      3'd1: begin d_row = 4'hF; d_col = 4'h0; end
      3'd2: begin d_row = 4'h0; d_col = 4'h1; end
      3'd3: begin d_row = 4'h0; d_col = 4'hF; end
      3'd4: begin d_row = 4'h1; d_col = 4'h1; end
      3'd5: begin d_row = 4'h1; d_col = 4'hF; end
      3'd6: begin d_row = 4'hF; d_col = 4'h1; end
      3'd7: begin d_row = 4'hF; d_col = 4'hF; end
    endcase
  end

  // Rows/cols start in 0..7, so a single step lands in -1..8. Both -1 (4'hF)
  // and 8 (4'h8) set bit 3, which therefore flags "off board".
  assign cand_row = {1'b0, cur[5:3]} + d_row;
  assign cand_col = {1'b0, cur[2:0]} + d_col;
  assign cand_off = cand_row[3] | cand_col[3];
  assign cand     = {cand_row[2:0], cand_col[2:0]};
  assign cand_pc  = board[cand];
  assign src_pc   = board[from_sq];
  assign cand_own = (cand_pc.piece != EMPTY) && (cand_pc.color == mover);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      src          <= '0;
      cur          <= '0;
      dir          <= '0;
      last_dir     <= DIR_W;
      mover        <= WHITE;
      slider       <= 1'b0;
      ray_end      <= 1'b0;
      move_to      <= '0;
      move_capture <= 1'b0;
      move_valid   <= 1'b0;
      move_count   <= '0;
    end else begin
      state        <= state_n;
      src          <= src_n;
      cur          <= cur_n;
      dir          <= dir_n;
      last_dir     <= last_dir_n;
      mover        <= mover_n;
      slider       <= slider_n;
      ray_end      <= ray_end_n;
      move_to      <= move_to_n;
      move_capture <= move_capture_n;
      move_valid   <= move_valid_n;
      move_count   <= move_count_n;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_n        = state;
    src_n          = src;
    cur_n          = cur;
    dir_n          = dir;
    last_dir_n     = last_dir;
    mover_n        = mover;
    slider_n       = slider;
    ray_end_n      = ray_end;
    move_to_n      = move_to;
    move_capture_n = move_capture;
    move_valid_n   = move_valid;
    move_count_n   = move_count;

    unique case (state)
      IDLE: begin
        if (start) begin
          src_n        = from_sq;
          cur_n        = from_sq;
          mover_n      = src_pc.color;
          slider_n     = (src_pc.piece == ROOK) || (src_pc.piece == QUEEN);
          dir_n        = 3'd0;
          ray_end_n    = 1'b0;
          move_count_n = '0;
`ifdef ROOKGEN_DIAG_EN
          last_dir_n   = (src_pc.piece == QUEEN) ? DIR_SW : DIR_W;
`else
          last_dir_n   = DIR_W;
`endif
          state_n      = SCAN;
        end
      end

      SCAN: begin
        if (!slider) begin
          state_n = FIN;
        end else if (cand_off || cand_own) begin
          // Ray blocked without a target: next direction or finish.
          if (dir == last_dir) begin
            state_n = FIN;
          end else begin
            dir_n = dir + 3'd1;
            cur_n = src;
          end
        end else begin
          move_to_n      = cand;
          move_valid_n   = 1'b1;
          cur_n          = cand;
          move_capture_n = (cand_pc.piece != EMPTY);
          ray_end_n      = (cand_pc.piece != EMPTY);
          state_n        = EMIT;
        end
      end

      EMIT: begin
        if (move_ready) begin
          move_valid_n = 1'b0;
          move_count_n = move_count + CNT_W'(1);
          state_n      = SCAN;
          if (ray_end) begin
            // A capture closes the ray; skip the pointless off-ray probe.
            ray_end_n = 1'b0;
            if (dir == last_dir) begin
              state_n = FIN;
            end else begin
              dir_n = dir + 3'd1;
              cur_n = src;
            end
          end
        end
      end

      FIN: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_rook_move_gen.sv
// tb/tb_rook_move_gen.sv - self-checking bench for rook_move_gen
module tb_rook_move_gen;
  import rook_move_gen_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  fullpiece_t [63:0] board;
  logic [5:0]        from_sq;
  logic              start;
  logic              busy;
  logic              move_valid;
  logic              move_ready;
  logic [5:0]        move_to;
  logic              move_capture;
  logic              done;
  logic [4:0]        move_count;

  int total = 0;
  int bad   = 0;

  int exp_to[$];
  int exp_cap[$];
  int first_valid_cyc;
  int done_cyc;
  int last_stalls;

  rook_move_gen #(.CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .board        (board),
    .from_sq      (from_sq),
    .start        (start),
    .busy         (busy),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .move_to      (move_to),
    .move_capture (move_capture),
    .done         (done),
    .move_count   (move_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = '{color: WHITE, piece: EMPTY};
  endtask

  // Reference move list: walk each ray on an 8x8 grid with plain integers.
  task automatic model(input int src);
    int dr[8];
    int dc[8];
    int ndir, r, c, t;
    fullpiece_t p;
    dr = '{1, -1, 0, 0, 1, 1, -1, -1};
    dc = '{0, 0, 1, -1, 1, -1, 1, -1};
    exp_to.delete();
    exp_cap.delete();
    p = board[src];
    if (p.piece != ROOK && p.piece != QUEEN) return;
    ndir = 4;
`ifdef ROOKGEN_DIAG_EN
    if (p.piece == QUEEN) ndir = 8;
`endif
    for (int d = 0; d < ndir; d++) begin
      r = src / 8;
      c = src % 8;
      while (1) begin
        r += dr[d];
        c += dc[d];
        if (r < 0 || r > 7 || c < 0 || c > 7) break;
        t = r * 8 + c;
        if (board[t].piece == EMPTY) begin
          exp_to.push_back(t);
          exp_cap.push_back(0);
        end else if (board[t].color != p.color) begin
          exp_to.push_back(t);
          exp_cap.push_back(1);
          break;
        end else begin
          break;
        end
      end
    end
  endtask

  // One run: start on src, consume moves with ready probability rdy_pct,
  // stall the first move for hold_first cycles, optionally raise reset on
  // the abort_at-th handshake, optionally poke start while busy.
  task automatic run(input logic [5:0] src, input int rdy_pct, input int hold_first,
                     input int abort_at, input bit poke);
    int  cyc, got, stalls;
    bit  prev_valid, prev_rdy, seen_done, rdy;
    logic [5:0] prev_to;
    model(src);
    first_valid_cyc = -1;
    done_cyc = -1;
    from_sq = src;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; got = 0; stalls = 0;
    prev_valid = 0; prev_rdy = 0; prev_to = '0; seen_done = 0;
    check("busy_after_start", busy, 1);
    while (!seen_done && cyc < 600) begin
      if (prev_valid && !prev_rdy) begin
        check("hold_valid", move_valid, 1);
        check("hold_to", move_to, prev_to);
      end
      if (move_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        seen_done = 1;
        done_cyc = cyc;
        check("done_busy", busy, 1);
        check("done_no_valid", move_valid, 0);
        check("moves_seen", got, exp_to.size());
        check("move_count", move_count, exp_to.size());
        break;
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      if (move_valid && got == 0 && stalls < hold_first) begin
        rdy = 0;
        stalls++;
      end
      if (poke && cyc == 3) begin
        start = 1'b1;
        from_sq = src ^ 6'h2a;
      end else begin
        start = 1'b0;
      end
      move_ready = rdy;
      if (move_valid && rdy) begin
        if (got < exp_to.size()) begin
          check("move_to", move_to, exp_to[got]);
          check("move_capture", move_capture, exp_cap[got]);
        end else begin
          check("extra_move", got, exp_to.size());
        end
        got++;
        if (got == abort_at) begin
          reset = 1'b1;
          break;
        end
      end
      prev_valid = move_valid;
      prev_rdy = rdy;
      prev_to = move_to;
      @(negedge clk);
      cyc++;
    end
    last_stalls = stalls;
    if (abort_at == 0) begin
      check("done_seen", seen_done, 1);
      // start during FIN must be ignored
      start = 1'b1;
      move_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("idle_busy", busy, 0);
      check("done_pulse_1cyc", done, 0);
      check("count_held", move_count, exp_to.size());
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    move_ready = 1'b0;
    from_sq = '0;
    clear_board();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", move_valid, 0);
    check("rst_done", done, 0);
    check("rst_capture", move_capture, 0);
    check("rst_to", move_to, 0);
    check("rst_count", move_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Empty board, white rook at 0, ready always high.
    board[0] = '{color: WHITE, piece: ROOK};
    run(6'd0, 100, 0, 0, 0);
    check("t1_count14", move_count, 14);
    check("t1_first_valid_cyc", first_valid_cyc, 2);

    // Rook at 27 with own pawn at 35 and enemy pawn at 19.
    clear_board();
    board[27] = '{color: WHITE, piece: ROOK};
    board[35] = '{color: WHITE, piece: PAWN};
    board[19] = '{color: BLACK, piece: PAWN};
    run(6'd27, 100, 0, 0, 0);
    check("t2_count8", move_count, 8);

    // Empty source square.
    clear_board();
    run(6'd12, 100, 0, 0, 0);
    check("t3_done_cyc", done_cyc, 2);
    check("t3_no_valid", first_valid_cyc, -1);

    // Backpressure on the first move.
    board[0] = '{color: WHITE, piece: ROOK};
    run(6'd0, 100, 5, 0, 0);
    check("t4_stalls", last_stalls, 5);

    // Reset on the third accepted move, then rerun.
    run(6'd0, 100, 0, 3, 0);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", move_valid, 0);
    check("abort_done", done, 0);
    check("abort_count", move_count, 0);
    @(negedge clk);
    check("abort_done2", done, 0);
    reset = 1'b0;
    @(negedge clk);
    run(6'd0, 100, 0, 0, 0);
    check("t5_count14", move_count, 14);

    // Queen on empty board: diagonals only with the optional build.
    clear_board();
    board[0] = '{color: BLACK, piece: QUEEN};
    run(6'd0, 100, 0, 0, 0);
`ifdef ROOKGEN_DIAG_EN
    n = 21;
`else
    n = 14;
`endif
    check("t6_queen_count", move_count, n);

    // Random boards, random source piece, random backpressure, busy pokes.
    for (int k = 0; k < 40; k++) begin
      int s;
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 99) < 55) board[i] = '{color: WHITE, piece: EMPTY};
        else board[i] = '{color: color_t'($urandom_range(0, 1)),
                          piece: piece_t'($urandom_range(1, 6))};
      end
      s = $urandom_range(0, 63);
      case ($urandom_range(0, 9))
        0:       board[s].piece = BISHOP;
        1, 2, 3: board[s].piece = QUEEN;
        default: board[s].piece = ROOK;
      endcase
      run(6'(s), $urandom_range(30, 100), $urandom_range(0, 3), 0, (k % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rook_move_gen.md
Name: rook_move_gen

Overview:
Sequential sliding-piece move generator. It is the attacker-side counterpart of the combinational rook check detectors. Given a board and a source square holding a rook (or queen), it walks each ray one square per cycle. It emits every legal pseudo-move target over a valid/ready stream, then signals completion. The move-list builder in the search engine consumes its output.

Parameters:
CNT_W, 5, width of move_count; must hold the maximum move count (27 in the wider build).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
board  input  fullpiece_t[63:0]  board array; caller holds it stable from start until done
from_sq  input  6  source square index (row = [5:3], col = [2:0]); sampled on start
start  input  1  one-cycle request; ignored while busy
busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive
move_valid  output  1  move_to and move_capture are valid
move_ready  input  1  consumer accepts the move when move_valid && move_ready
move_to  output  6  target square index
move_capture  output  1  target holds an enemy piece
done  output  1  one-cycle pulse after the last move is accepted or the rays are exhausted
move_count  output  CNT_W  number of moves accepted in the last run; valid at done, held until next accepted start

Behaviour:
- Reset: state=IDLE. busy, move_valid, done, move_capture = 0. move_to = 0, move_count = 0. Reset mid-run aborts immediately; no done pulse; move_valid drops on the next edge.
- States: IDLE, SCAN, EMIT, FIN.
- IDLE + start: latch from_sq into cur and src. Latch mover = board[from_sq].color. dir = N. Clear the count. Go to SCAN.
- If the piece at from_sq is not ROOK or QUEEN (EMPTY included), SCAN goes straight to FIN. Zero moves result.
- Ray order: N (row+1), S (row-1), E (col+1), W (col-1).
- SCAN evaluates one candidate per cycle, cand = cur stepped in dir, using 4-bit signed row/col arithmetic:
  - off board (row or col outside 0..7): advance dir; cur = src.
  - EMPTY: register move_to=cand, move_capture=0, move_valid=1; cur=cand; go to EMIT (ray continues).
  - enemy colour: register move_to=cand, move_capture=1, move_valid=1; mark ray ended; go to EMIT.
  - own colour: advance dir; cur = src; no emit.
  - After W is exhausted: go to FIN.
- EMIT: hold move_to, move_capture and move_valid stable while move_ready=0. On handshake: move_valid=0 and move_count++. Then return to SCAN, either continuing the ray or on the next dir if the ray ended.
- FIN: done=1 for exactly one cycle, then go to IDLE. busy drops the same cycle done drops.
- Latency: start in cycle 0 → SCAN in cycle 1 → earliest move_valid in cycle 2. Throughput with ready held high is one move per 2 cycles, plus 1 cycle per blocked or off-board probe.
- start while busy: ignored, no effect.
- move_ready while move_valid=0: no effect.
- start in the same cycle as FIN: ignored. The caller re-issues it in IDLE.
- Board changes during a run give undefined move content, but the FSM must still terminate.

Optional Feature:
ROOKGEN_DIAG_EN.
- Defined: when the source piece is QUEEN, rays NE, NW, SE, SW are scanned after W, with the same rules; a ROOK still scans only the 4 orthogonal rays. Maximum count is 27.
- Undefined: QUEEN is treated as ROOK (orthogonal rays only). Maximum count is 14.

Test Plan:
- Empty board with white ROOK at 0, start, move_ready=1 → moves 8,16,24,32,40,48,56,1,2,3,4,5,6,7 in that order, all capture=0; done with move_count=14.
- White ROOK at 27, white pawn at 35, black pawn at 19 → moves 19(capture=1),28,29,30,31,26,25,24; move_count=8; square 35 never emitted.
- EMPTY at from_sq=12 → no move_valid; done in cycle 2; move_count=0.
- Backpressure: ROOK at 0, move_ready=0 for 5 cycles at the first move → move_to=8 held stable with move_valid=1 for 5 cycles; the sequence then continues unchanged.
- Reset asserted on the 3rd accepted move, then start again → busy=0, move_valid=0, no done pulse; the next run restarts from the first move with move_count counted from 0.
- ROOKGEN_DIAG_EN defined, QUEEN at 0, empty board → 21 moves; the last 7 are 9,18,27,36,45,54,63; move_count=21. Without the macro → 14 moves.
